// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - streams a kernel block, then every KxK image window in raster order,
// to a downstream convolver over a valid/ready beat interface.
module window_feeder #(
  parameter int KERNEL_SIZE     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int IMG_W           = 4,
  parameter int SRAM_ADDR_WIDTH = 4,
  parameter int SRAM_DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic                       i_wr_sel,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic                       i_start,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic                       o_kernel,
  output logic [SRAM_ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int KK = K * K;
  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int KW = (KK > 1) ? $clog2(KK) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [KW-1:0] KLAST   = KW'(KK - 1);
  localparam logic [CW-1:0] KM1     = CW'(K - 1);
  localparam logic [CW-1:0] WLAST   = CW'(IMG_W - K);
  localparam logic [AW:0]   KK_A    = (AW + 1)'(KK);
  localparam logic [AW:0]   DEPTH_A = (AW + 1)'(SRAM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_KERNEL, S_WINDOW, S_DONE} state_t;

  state_t           state;
  logic [KW-1:0]    kidx;
  logic [CW-1:0]    kr, kc, wr, wc;

  logic [DW-1:0]    img_mem [SRAM_DEPTH];
  logic [DW-1:0]    ker_mem [KK];

  logic [KW-1:0]    kidx_nxt;
  logic [CW-1:0]    nkr, nkc, nwr, nwc;
  logic             win_end, pass_end, nxt_last;
  logic [AW-1:0]    nxt_addr;

  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
    logic [31:0] a;
    a = 32'(r) * IMG_W + 32'(c);
    return a[AW-1:0];
  endfunction

  // Stores are frozen for the whole pass so a window never sees a half-updated image.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !o_busy) begin
      if (!i_wr_sel) begin
        if ({1'b0, i_wr_addr} < DEPTH_A) img_mem[i_wr_addr] <= i_wr_data;
      end else if ({1'b0, i_wr_addr} < KK_A) begin
        ker_mem[KW'(i_wr_addr)] <= i_wr_data;
      end
    end
  end

  always_comb begin
    kidx_nxt = kidx + 1'b1;
    win_end  = (kr == KM1) && (kc == KM1);
    pass_end = win_end && (wr == WLAST) && (wc == WLAST);
    nkr = kr;
    nkc = kc;
    nwr = wr;
    nwc = wc;
    if (kc != KM1) begin
      nkc = kc + 1'b1;
    end else begin
      nkc = '0;
      if (kr != KM1) begin
        nkr = kr + 1'b1;
      end else begin
        nkr = '0;
        if (wc != WLAST) begin
          nwc = wc + 1'b1;
        end else begin
          nwc = '0;
          nwr = wr + 1'b1;
        end
      end
    end
    nxt_addr = pix_addr(nwr + nkr, nwc + nkc);
    nxt_last = (nkr == KM1) && (nkc == KM1);
  end

  // Outputs are loaded with the next beat on each handshake, so there are no bubbles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      kidx     <= '0;
      kr       <= '0;
      kc       <= '0;
      wr       <= '0;
      wc       <= '0;
      o_valid  <= 1'b0;
      o_kernel <= 1'b0;
      o_addr   <= '0;
      o_data   <= '0;
      o_last   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state    <= S_KERNEL;
            kidx     <= '0;
            o_valid  <= 1'b1;
            o_busy   <= 1'b1;
            o_kernel <= 1'b1;
            o_addr   <= '0;
            o_data   <= ker_mem[0];
            o_last   <= (KK == 1);
          end
        end
        S_KERNEL: begin
          if (i_ready) begin
            if (kidx == KLAST) begin
              state    <= S_WINDOW;
              kr       <= '0;
              kc       <= '0;
              wr       <= '0;
              wc       <= '0;
              o_kernel <= 1'b0;
              o_addr   <= '0;
              o_data   <= img_mem[0];
              o_last   <= (K == 1);
            end else begin
              kidx   <= kidx_nxt;
              o_addr <= AW'(kidx_nxt);
              o_data <= ker_mem[kidx_nxt];
              o_last <= (kidx_nxt == KLAST);
            end
          end
        end
        S_WINDOW: begin
          if (i_ready) begin
            if (pass_end) begin
              state    <= S_DONE;
              kr       <= '0;
              kc       <= '0;
              wr       <= '0;
              wc       <= '0;
              o_valid  <= 1'b0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
              o_kernel <= 1'b0;
              o_addr   <= '0;
              o_data   <= '0;
              o_last   <= 1'b0;
            end else begin
              kr     <= nkr;
              kc     <= nkc;
              wr     <= nwr;
              wc     <= nwc;
              o_addr <= nxt_addr;
              o_data <= img_mem[nxt_addr];
              o_last <= nxt_last;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_feeder.sv
// tb/tb_window_feeder.sv - randomized bench for window_feeder against a beat-list model.
module tb_window_feeder;
  localparam int K = 3, DW = 8, W = 4, AW = 4, DEPTH = 16;
  localparam int KK = K * K, NW = W - K + 1, NB = KK + NW * NW * KK;

  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, ready = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic o_valid, o_kernel, o_last, o_busy, o_done;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;

  window_feeder #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .IMG_W(W), .SRAM_ADDR_WIDTH(AW), .SRAM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .i_ready(ready), .o_valid(o_valid),
    .o_kernel(o_kernel), .o_addr(o_addr), .o_data(o_data), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: store images plus the full expected beat list of a pass.
  logic [DW-1:0] img_m [DEPTH];
  logic [DW-1:0] ker_m [KK];
  logic          ek [NB];
  logic [AW-1:0] ea [NB];
  logic [DW-1:0] ed [NB];
  logic          el [NB];

  function automatic void build();
    int n = 0;
    for (int i = 0; i < KK; i++) begin
      ek[n] = 1'b1; ea[n] = AW'(i); ed[n] = ker_m[i]; el[n] = (i == KK - 1); n++;
    end
    for (int r = 0; r < NW; r++)
      for (int c = 0; c < NW; c++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            int a = (r + kr) * W + c + kc;
            ek[n] = 1'b0; ea[n] = AW'(a); ed[n] = img_m[a]; el[n] = (kr == K - 1 && kc == K - 1); n++;
          end
  endfunction

  bit rdy_mode = 1'b1;
  initial forever begin
    @(posedge clk); #2;
    ready = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Compare process: every negedge predicts and checks valid/busy/done and the beat payload.
  bit exp_active = 0, exp_done = 0, prev_stall = 0, hs, nxt_done;
  logic [13:0] prev_pl;
  int bi = 0, hs_in_pass = 0, done_count = 0, passes_done = 0, valid_cycles = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int last_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("reset_outputs", {o_valid, o_kernel, o_addr, o_data, o_last, o_busy, o_done}, 0);
      exp_active = 0; exp_done = 0; prev_stall = 0;
    end else begin
      check("valid", o_valid, exp_active);
      check("busy", o_busy, exp_active);
      check("done", o_done, exp_done);
      if (o_done) begin done_count++; done_cyc = cyc; end
      if (exp_active) begin
        if (o_valid) valid_cycles++;
        if (prev_stall) check("stall_hold", {o_kernel, o_addr, o_data, o_last}, prev_pl);
        if (bi < NB) check("beat", {o_kernel, o_addr, o_data, o_last}, {ek[bi], ea[bi], ed[bi], el[bi]});
      end
      hs = exp_active && ready;
      nxt_done = hs && (bi == NB - 1);
      if (hs) begin
        if (o_last) last_q.push_back(hs_in_pass + 1);
        bi++; hs_in_pass++;
      end
      prev_stall = exp_active && !ready;
      prev_pl = {o_kernel, o_addr, o_data, o_last};
      if (exp_active) exp_active = !nxt_done;
      else if (!exp_done && start) begin
        exp_active = 1; build(); bi = 0; hs_in_pass = 0; valid_cycles = 0;
        start_cyc = cyc; last_q.delete();
      end
      exp_done = nxt_done;
      if (nxt_done) passes_done++;
    end
  end

  task automatic host_wr(input bit sel, input int addr, input logic [DW-1:0] data);
    @(posedge clk); #2;
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    if (!sel) img_m[addr] = data;
    else if (addr < KK) ker_m[addr] = data;
  endtask

  task automatic host_wr_end();
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  // act: 0 plain pass, 1 busy write + restart at beat 10, 2 reset at beat 20
  task automatic run_pass(input bit mode, input int act);
    int base = passes_done;
    bit did = 0, ok = 0;
    rdy_mode = mode;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      wr_en = 1'b0; start = 1'b0; rst = 1'b0;
      if (act == 2 && did) begin ok = 1; break; end
      if (passes_done != base) begin ok = 1; break; end
      if (!did && act == 1 && hs_in_pass >= 10) begin
        did = 1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 8'hAA; start = 1'b1;
      end
      if (!did && act == 2 && hs_in_pass >= 20) begin
        did = 1; rst = 1'b1;
      end
    end
    if (!ok) check("pass_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  int lit_win [36] = '{0,1,2,4,5,6,8,9,10, 1,2,3,5,6,7,9,10,11,
                       4,5,6,8,9,10,12,13,14, 5,6,7,9,10,11,13,14,15};
  int dc;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) host_wr(0, a, DW'(a));
    for (int i = 0; i < KK; i++) host_wr(1, i, DW'(i + 1));
    host_wr(1, 9, 8'h77);
    host_wr(1, 15, 8'h66);
    host_wr_end();

    run_pass(1, 0);
    for (int i = 0; i < KK; i++) check("pin_kernel_data", ed[i], i + 1);
    for (int i = 0; i < 36; i++) begin
      check("pin_window_addr", ea[KK + i], lit_win[i]);
      check("pin_window_data", ed[KK + i], lit_win[i]);
    end
    check("pass1_beats", hs_in_pass, 45);
    check("pass1_valid_cycles", valid_cycles, 45);
    check("pass1_done_latency", done_cyc - start_cyc, 46);
    check("pass1_last_count", last_q.size(), 5);
    for (int i = 0; i < last_q.size() && i < 5; i++) check("pass1_last_pos", last_q[i], 9 * (i + 1));
    check("pass1_done_count", done_count, 1);

    run_pass(0, 1);
    check("pass2_beats", hs_in_pass, 45);
    check("pass2_done_count", done_count, 2);

    run_pass(0, 0);
    check("pass3_done_count", done_count, 3);

    for (int a = 0; a < DEPTH; a++) host_wr(0, a, DW'($urandom));
    for (int i = 0; i < KK; i++) host_wr(1, i, DW'($urandom));
    host_wr_end();
    run_pass(0, 0);
    check("pass4_done_count", done_count, 4);

    dc = done_count;
    run_pass(1, 2);
    repeat (5) @(posedge clk);
    check("reset_no_done", done_count, dc);
    run_pass(0, 0);
    check("post_reset_beats", hs_in_pass, 45);
    check("post_reset_done_count", done_count, dc + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
